// File: rtl/blake2_round_ctrl.sv
// BLAKE2b round sequencer: holds the working vector v and message block m and
// applies alternating column/diagonal G steps through four parallel G units.

module blake2_g (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] c,
    input  logic [63:0] d,
    input  logic [63:0] x,
    input  logic [63:0] y,
    output logic [63:0] a_new,
    output logic [63:0] b_new,
    output logic [63:0] c_new,
    output logic [63:0] d_new
);

    logic [63:0] a1, b1, c1, d1;
    logic [63:0] b1_x, d1_x, b2_x, d2_x;

    // Rotation amounts 32/24/16/63 are fixed wiring, so they are plain concatenations.
    assign a1    = a + b + x;
    assign d1_x  = d ^ a1;
    assign d1    = {d1_x[31:0], d1_x[63:32]};
    assign c1    = c + d1;
    assign b1_x  = b ^ c1;
    assign b1    = {b1_x[23:0], b1_x[63:24]};

    assign a_new = a1 + b1 + y;
    assign d2_x  = d1 ^ a_new;
    assign d_new = {d2_x[15:0], d2_x[63:16]};
    assign c_new = c1 + d_new;
    assign b2_x  = b1 ^ c_new;
    assign b_new = {b2_x[62:0], b2_x[63]};

endmodule

module blake2_round_ctrl #(
    parameter int NUM_ROUNDS = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1023:0] v_in,
    input  logic [1023:0] m_in,
    output logic          ready,
    output logic [1023:0] v_out,
    output logic          v_valid,
    output logic [3:0]    round
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COL,
        DIAG,
        DONE
    } state_t;

    state_t state, state_next;

    logic        load;
    logic        step_en;
    logic        round_inc;
    logic        diag;

    logic [63:0] v      [16];
    logic [63:0] m      [16];
    logic [63:0] v_next [16];

    logic [3:0]  sigma_row_idx;
    logic [63:0] sigma_row;

    logic [3:0]  idx_a [4];
    logic [3:0]  idx_b [4];
    logic [3:0]  idx_c [4];
    logic [3:0]  idx_d [4];
    logic [63:0] g_a   [4];
    logic [63:0] g_b   [4];
    logic [63:0] g_c   [4];
    logic [63:0] g_d   [4];
    logic [63:0] g_x   [4];
    logic [63:0] g_y   [4];
    logic [63:0] r_a   [4];
    logic [63:0] r_b   [4];
    logic [63:0] r_c   [4];
    logic [63:0] r_d   [4];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        load       = 1'b0;
        step_en    = 1'b0;
        round_inc  = 1'b0;
        ready      = 1'b0;
        v_valid    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = COL;
                end
            end
            COL: begin
                step_en    = 1'b1;
                state_next = DIAG;
            end
            DIAG: begin
                step_en = 1'b1;
                if (round == LAST_ROUND) begin
                    state_next = DONE;
                end else begin
                    round_inc  = 1'b1;
                    state_next = COL;
                end
            end
            DONE: begin
                ready   = 1'b1;
                v_valid = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = COL;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign diag = (state == DIAG);

    // ------------------------------------------------------------------
    // Sigma ROM: row packed as 16 nibbles, entry k at bits [4k+3:4k]
    // ------------------------------------------------------------------
    assign sigma_row_idx = (round >= 4'd10) ? round - 4'd10 : round;

    always_comb begin
        case (sigma_row_idx)
            4'd0:    sigma_row = 64'hFEDCBA98_76543210;
            4'd1:    sigma_row = 64'h357B20C1_6DF984AE;
            4'd2:    sigma_row = 64'h491763EA_DF250C8B;
            4'd3:    sigma_row = 64'h8F04A562_EBCD1397;
            4'd4:    sigma_row = 64'hD386CB1E_FA427509;
            4'd5:    sigma_row = 64'h91EF57D4_38B0A6C2;
            4'd6:    sigma_row = 64'hB8293670_A4DEF15C;
            4'd7:    sigma_row = 64'hA2684F05_931CE7BD;
            4'd8:    sigma_row = 64'h5A417D2C_803B9EF6;
            4'd9:    sigma_row = 64'h0DC3E9BF_5167482A;
            default: sigma_row = 64'hFEDCBA98_76543210;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand routing: columns use (i, i+4, i+8, i+12); diagonals shift
    // rows 1..3 left by 1..3 positions.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx_a[i] = 4'(i);
            idx_b[i] = diag ? 4'(4 + ((i + 1) % 4))  : 4'(4 + i);
            idx_c[i] = diag ? 4'(8 + ((i + 2) % 4))  : 4'(8 + i);
            idx_d[i] = diag ? 4'(12 + ((i + 3) % 4)) : 4'(12 + i);
            g_a[i]   = v[idx_a[i]];
            g_b[i]   = v[idx_b[i]];
            g_c[i]   = v[idx_c[i]];
            g_d[i]   = v[idx_d[i]];
            g_x[i]   = m[sigma_row[4 * (2 * i + (diag ? 8 : 0)) +: 4]];
            g_y[i]   = m[sigma_row[4 * (2 * i + 1 + (diag ? 8 : 0)) +: 4]];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_unit
        blake2_g u_g (
            .a     (g_a[gi]),
            .b     (g_b[gi]),
            .c     (g_c[gi]),
            .d     (g_d[gi]),
            .x     (g_x[gi]),
            .y     (g_y[gi]),
            .a_new (r_a[gi]),
            .b_new (r_b[gi]),
            .c_new (r_c[gi]),
            .d_new (r_d[gi])
        );
    end

    // Each unit touches a disjoint set of four words, so write-back never collides.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            v_next[i] = v[i];
        end
        for (int i = 0; i < 4; i++) begin
            v_next[idx_a[i]] = r_a[i];
            v_next[idx_b[i]] = r_b[i];
            v_next[idx_c[i]] = r_c[i];
            v_next[idx_d[i]] = r_d[i];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round <= 4'd0;
            // NOTE: v and m are flop arrays (not RAM), so clearing them on reset is cheap and keeps v_out defined.
            for (int i = 0; i < 16; i++) begin
                v[i] <= 64'd0;
                m[i] <= 64'd0;
            end
        end else if (load) begin
            round <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                v[i] <= v_in[64 * i +: 64];
                m[i] <= m_in[64 * i +: 64];
            end
        end else if (step_en) begin
            for (int i = 0; i < 16; i++) begin
                v[i] <= v_next[i];
            end
            if (round_inc) begin
                round <= round + 4'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            v_out[64 * i +: 64] = v[i];
        end
    end

endmodule

// File: doc/blake2_round_ctrl.md
Name: blake2_round_ctrl

Overview:
Sequences the BLAKE2b compression rounds over the 16-word working vector v. It holds v and the 16-word message block in registers and drives four parallel blake2_G instances. Each round is a column step followed by a diagonal step, one step per clock. It sits between the top-level BLAKE2b core, which builds v from h, IV, t and f and applies the final feed-forward, and the G datapath.

Parameters:
NUM_ROUNDS, 12, number of rounds per compression. Legal range 1..15; 12 gives BLAKE2b.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a compression. Sampled only when ready=1.
v_in  input  1024  initial working vector; word i is v_in[64*i+63 : 64*i].
m_in  input  1024  message block; word j is m_in[64*j+63 : 64*j].
ready  output  1  high when idle or done; start is accepted.
v_out  output  1024  working vector register, same word packing as v_in.
v_valid  output  1  one-cycle pulse: v_out holds the final vector.
round  output  4  current round index 0..NUM_ROUNDS-1 (debug/status).

Behaviour:
- Reset (async, high): state=IDLE; v, m, round, step all cleared to 0. Outputs: ready=1, v_valid=0, v_out=0, round=0.
- FSM states: IDLE, COL, DIAG, DONE.
  - IDLE: ready=1. On start=1, load v<=v_in, m<=m_in, round<=0, then go to COL.
  - COL: apply the column step to v, then go to DIAG.
  - DIAG: apply the diagonal step to v.
    - If round==NUM_ROUNDS-1, go to DONE.
    - Otherwise round<=round+1 and go to COL.
  - DONE: v_valid=1 and ready=1 for exactly one cycle.
    - On start=1, perform the same load as IDLE and go to COL (back-to-back operation).
    - Otherwise go to IDLE.
- Schedule index: s = SIGMA[round mod 10], using the standard BLAKE2 sigma table (RFC 7693 §2.7). Rounds 10 and 11 reuse rows 0 and 1. Implement sigma as a combinational ROM.
- Column step (4 G units in parallel):
  - G(v0,v4,v8,v12; m[s0],m[s1])
  - G(v1,v5,v9,v13; m[s2],m[s3])
  - G(v2,v6,v10,v14; m[s4],m[s5])
  - G(v3,v7,v11,v15; m[s6],m[s7])
- Diagonal step:
  - G(v0,v5,v10,v15; m[s8],m[s9])
  - G(v1,v6,v11,v12; m[s10],m[s11])
  - G(v2,v7,v8,v13; m[s12],m[s13])
  - G(v3,v4,v9,v14; m[s14],m[s15])
- G write-back: each unit's a',b',c',d' results are written to the same v indices it read from. All 16 words update on the same edge.
- Latency: start sampled at edge N.
  - COL/DIAG updates occur at edges N+1 .. N+2*NUM_ROUNDS.
  - v_valid=1 in the cycle after edge N+2*NUM_ROUNDS; that is edge N+25 for the default.
  - Throughput: one compression per 2*NUM_ROUNDS+1 cycles when back-to-back.
- start while in COL or DIAG is ignored; there is no queuing. v_in and m_in are not observed after the load edge.
- v_out always reflects the v register. It is stable from DONE until the next accepted start. During operation it shows intermediate values, which are not valid.
- m is never modified during a compression.
- The round counter saturates logically at NUM_ROUNDS-1; it never wraps while busy.
- Reset asserted mid-compression aborts immediately to IDLE with all registers cleared. No v_valid pulse is produced.
- All arithmetic is mod 2^64 inside G. No other arithmetic exists beyond the round counter.

Test Plan:
1. Reset release -> ready=1, v_valid=0, v_out=0, round=0. Hold start=0 for 10 cycles -> no state change.
2. RFC 7693 "abc" vector:
   - Stimulus: v_in = {h with h0=IV0^0x01010040, IV}, v12^=3, v14=~v14; m0=0x0000000000636261, other words 0.
   - Response: v_valid exactly 25 cycles after start. Feed-forward h0^v0^v8 = 0x0D4D1C983FA580BA.
3. Random v_in/m_in, 200 vectors vs software model (NUM_ROUNDS=12) -> bit-exact v_out. Also check round steps 0..11 with two cycles per value.
4. Back-to-back: start held high through DONE -> second compression begins with no IDLE cycle. v_valid pulses 25 cycles apart; both results correct.
5. start pulsed at cycle 7 of a compression, with different v_in -> ignored; result equals the first operation's model output.
6. Reset asserted at cycle 13, then start with a new vector -> immediate ready=1, v_out=0, no v_valid. The next start yields the correct result for the new vector.
